// File: rtl/id_stage_if.sv
// Fetch-to-decode handshake: IF drives instruction and pc, ID returns ready.
interface id_stage_if #(
  parameter int unsigned PC_W = 32
) ();
  logic            valid;
  logic            ready;
  logic [31:0]     instr;
  logic [PC_W-1:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/id_stage.sv
// RV32I(+M) decode pipeline stage: decodes the incoming word combinationally and presents the
// fields from an output register, with flush and one-bubble load-use stall.
module id_stage #(
  parameter bit          EN_M      = 1'b1,
  parameter bit          EN_HAZARD = 1'b1,
  parameter int unsigned PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  id_stage_if.slave       fetch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output logic [6:0]      opcode,
  output logic [4:0]      op,
  output logic [1:0]      ldsz,
  output logic            ldsx,
  output logic            ill
);

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcReg    = 7'b0110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [6:0]      opcode;
    logic [4:0]      op;
    logic [1:0]      ldsz;
    logic            ldsx;
    logic            ill;
  } dec_t;

  dec_t dec_d, dec_q;
  logic valid_q;
  logic stall, accept;

  logic [31:0] instr;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic        m_op, alt;

  assign instr = fetch.instr;
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};

  always_comb begin
    dec_d        = '0;
    m_op         = 1'b0;
    alt          = 1'b0;
    dec_d.pc     = fetch.pc;
    dec_d.opcode = instr[6:0];
    dec_d.ldsz   = f3[1] ? 2'b11 : {1'b0, f3[0]};
    case (instr[6:0])
      OpcLui, OpcAuipc: begin
        dec_d.rd  = instr[11:7];
        dec_d.imm = {instr[31:12], 12'b0};
      end
      OpcJal: begin
        dec_d.rd  = instr[11:7];
        dec_d.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OpcJalr: begin
        dec_d.rd  = instr[11:7];
        dec_d.rs1 = instr[19:15];
        dec_d.imm = imm_i;
        dec_d.ill = (f3 != 3'b000);
      end
      OpcBranch: begin
        dec_d.rs1 = instr[19:15];
        dec_d.rs2 = instr[24:20];
        dec_d.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        dec_d.ill = (f3[2:1] == 2'b01);
      end
      OpcLoad: begin
        dec_d.rd   = instr[11:7];
        dec_d.rs1  = instr[19:15];
        dec_d.imm  = imm_i;
        dec_d.ldsx = (f3[2:1] == 2'b00);
        dec_d.ill  = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OpcStore: begin
        dec_d.rs1 = instr[19:15];
        dec_d.rs2 = instr[24:20];
        dec_d.imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
        dec_d.ill = (f3 > 3'b010);
      end
      OpcImm: begin
        dec_d.rd  = instr[11:7];
        dec_d.rs1 = instr[19:15];
        dec_d.imm = imm_i;
        if (f3 == 3'b001) begin
          dec_d.ill = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          alt       = instr[30];
          dec_d.ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        end
      end
      OpcReg: begin
        dec_d.rd  = instr[11:7];
        dec_d.rs1 = instr[19:15];
        dec_d.rs2 = instr[24:20];
        if (f7 == 7'b0000001) begin
          m_op      = EN_M;
          dec_d.ill = !EN_M;
        end else begin
          // Only ADD/SUB and SRL/SRA have an alternate encoding.
          alt       = ((f3 == 3'b000) || (f3 == 3'b101)) && instr[30];
          dec_d.ill = !((f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
        end
      end
      default: dec_d.ill = 1'b1;
    endcase
    dec_d.op = {m_op, alt, f3};
  end

  // Unused source fields decode to 0, and held rd is nonzero here, so plain compares suffice.
  assign stall = EN_HAZARD && valid_q && (dec_q.opcode == OpcLoad) && (dec_q.rd != 5'd0) &&
                 ((dec_d.rs1 == dec_q.rd) || (dec_d.rs2 == dec_q.rd));

  assign fetch.ready = (!valid_q || out_ready) && !stall && !flush;
  assign accept      = fetch.valid && fetch.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      dec_q   <= dec_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = dec_q.pc;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign rd        = dec_q.rd;
  assign imm       = dec_q.imm;
  assign opcode    = dec_q.opcode;
  assign op        = dec_q.op;
  assign ldsz      = dec_q.ldsz;
  assign ldsx      = dec_q.ldsx;
  assign ill       = dec_q.ill;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a default instance plus an EN_M=0/EN_HAZARD=0 instance that
// receive identical stimulus.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst, flush, out_ready;
  always #5 clk = ~clk;

  id_stage_if #(.PC_W(32)) bus ();
  id_stage_if #(.PC_W(32)) bus_nm ();

  logic        out_valid, ldsx, ill;
  logic [31:0] out_pc, imm;
  logic [4:0]  rs1, rs2, rd, op;
  logic [6:0]  opcode;
  logic [1:0]  ldsz;

  logic        nm_out_valid, nm_ldsx, nm_ill;
  logic [31:0] nm_out_pc, nm_imm;
  logic [4:0]  nm_rs1, nm_rs2, nm_rd, nm_op;
  logic [6:0]  nm_opcode;
  logic [1:0]  nm_ldsz;

  id_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch(bus.slave),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .opcode(opcode), .op(op),
    .ldsz(ldsz), .ldsx(ldsx), .ill(ill)
  );

  id_stage #(.EN_M(1'b0), .EN_HAZARD(1'b0), .PC_W(32)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .fetch(bus_nm.slave),
    .out_valid(nm_out_valid), .out_ready(out_ready), .out_pc(nm_out_pc),
    .rs1(nm_rs1), .rs2(nm_rs2), .rd(nm_rd), .imm(nm_imm), .opcode(nm_opcode), .op(nm_op),
    .ldsz(nm_ldsz), .ldsx(nm_ldsx), .ill(nm_ill)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.valid    = v;
    bus.instr    = instr;
    bus.pc       = pc;
    bus_nm.valid = v;
    bus_nm.instr = instr;
    bus_nm.pc    = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream: ADDI x1,x0,5 / LUI x7,0x12345 / SW x3,8(x2) / BEQ x1,x2,-4
  localparam logic [31:0] S_INSTR [4] = '{32'h00500093, 32'h123453B7, 32'h00312423, 32'hFE208EE3};
  localparam logic [31:0] S_IMM   [4] = '{32'h5, 32'h12345000, 32'h8, 32'hFFFFFFFC};
  localparam logic [4:0]  S_RD    [4] = '{5'd1, 5'd7, 5'd0, 5'd0};
  localparam logic [4:0]  S_RS2   [4] = '{5'd0, 5'd0, 5'd3, 5'd2};

  // Sweep: bad opcode, JALR f3=1, SLLI f7=0100000, SRAI, LH x4, SUB, SLL f7=0100000, LOAD f3=3
  localparam logic [31:0] W_INSTR [8] = '{32'h0000707F, 32'h000110E7, 32'h40309093, 32'h4030D093,
                                          32'h00011203, 32'h402081B3, 32'h402091B3, 32'h00013203};
  localparam logic        W_ILL   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [4:0]  W_OP    [8] = '{5'b00111, 5'b00001, 5'b00001, 5'b01101,
                                          5'b00001, 5'b01000, 5'b00001, 5'b00011};

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    step();
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_imm", imm, 32'h0);
    check("rst_op", {27'b0, op}, 32'h0);
    check("rst_ill", {31'b0, ill}, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    rst = 1'b0;

    // First instruction, one-cycle latency
    drive(1'b1, 32'h00500093, 32'h100);
    #1 check("first_ready", {31'b0, bus.ready}, 32'h1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("first_valid", {31'b0, out_valid}, 32'h1);
    check("first_rd", {27'b0, rd}, 32'd1);
    check("first_rs1", {27'b0, rs1}, 32'd0);
    check("first_imm", imm, 32'd5);
    check("first_op", {27'b0, op}, 32'd0);
    check("first_ill", {31'b0, ill}, 32'd0);
    check("first_pc", out_pc, 32'h100);
    out_ready = 1'b1;
    step();
    check("drain_valid", {31'b0, out_valid}, 32'h0);

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, S_INSTR[i], 32'h100 + 32'(i) * 4);
      step();
      check("strm_valid", {31'b0, out_valid}, 32'h1);
      check("strm_pc", out_pc, 32'h100 + 32'(i) * 4);
      check("strm_rd", {27'b0, rd}, {27'b0, S_RD[i]});
      check("strm_rs2", {27'b0, rs2}, {27'b0, S_RS2[i]});
      check("strm_imm", imm, S_IMM[i]);
    end

    // Backpressure: outputs frozen, no accept
    out_ready = 1'b0;
    drive(1'b1, 32'h00700113, 32'h110);
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_ready", {31'b0, bus.ready}, 32'h0);
      check("hold_valid", {31'b0, out_valid}, 32'h1);
      check("hold_pc", out_pc, 32'h10C);
      check("hold_imm", imm, 32'hFFFFFFFC);
      step();
    end
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("hold_drain", {31'b0, out_valid}, 32'h0);

    // Load-use: LW x5,0(x2) then ADD x6,x5,x1
    drive(1'b1, 32'h00012283, 32'h200);
    step();
    check("lw_valid", {31'b0, out_valid}, 32'h1);
    check("lw_opcode", {25'b0, opcode}, 32'h03);
    check("lw_ldsz", {30'b0, ldsz}, 32'h3);
    check("lw_ldsx", {31'b0, ldsx}, 32'h0);
    drive(1'b1, 32'h00128333, 32'h204);
    #1 check("stall_ready", {31'b0, bus.ready}, 32'h0);
    step();
    check("bubble", {31'b0, out_valid}, 32'h0);
    check("nohaz_valid", {31'b0, nm_out_valid}, 32'h1);
    check("nohaz_pc", nm_out_pc, 32'h204);
    #1 check("unstall_ready", {31'b0, bus.ready}, 32'h1);
    step();
    check("add_valid", {31'b0, out_valid}, 32'h1);
    check("add_pc", out_pc, 32'h204);
    check("add_rd", {27'b0, rd}, 32'd6);
    check("add_rs1", {27'b0, rs1}, 32'd5);
    check("add_rs2", {27'b0, rs2}, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    step();

    // Same pair targeting x0: no bubble
    drive(1'b1, 32'h00012003, 32'h220);
    step();
    check("lw0_valid", {31'b0, out_valid}, 32'h1);
    drive(1'b1, 32'h00100333, 32'h224);
    #1 check("lw0_ready", {31'b0, bus.ready}, 32'h1);
    step();
    check("add0_valid", {31'b0, out_valid}, 32'h1);
    check("add0_pc", out_pc, 32'h224);
    drive(1'b0, 32'h0, 32'h0);
    step();

    // Flush drops the presented instruction
    drive(1'b1, 32'h00500093, 32'h300);
    step();
    check("pre_flush_valid", {31'b0, out_valid}, 32'h1);
    drive(1'b1, 32'h123454B7, 32'h304);
    flush = 1'b1;
    #1 check("flush_ready", {31'b0, bus.ready}, 32'h0);
    step();
    flush = 1'b0;
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    drive(1'b1, 32'h00700113, 32'h308);
    step();
    check("post_flush_valid", {31'b0, out_valid}, 32'h1);
    check("post_flush_pc", out_pc, 32'h308);
    check("post_flush_rd", {27'b0, rd}, 32'd2);
    check("post_flush_imm", imm, 32'd7);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("post_flush_drain", {31'b0, out_valid}, 32'h0);

    // MUL x3,x1,x2 with and without M
    drive(1'b1, 32'h022081B3, 32'h400);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("mul_op", {27'b0, op}, 32'h10);
    check("mul_ill", {31'b0, ill}, 32'h0);
    check("mul_rd", {27'b0, rd}, 32'd3);
    check("mul_nm_valid", {31'b0, nm_out_valid}, 32'h1);
    check("mul_nm_ill", {31'b0, nm_ill}, 32'h1);
    check("mul_nm_op", {27'b0, nm_op}, 32'h0);
    step();

    // Legality sweep
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, W_INSTR[i], 32'h500 + 32'(i) * 4);
      step();
      check("swp_valid", {31'b0, out_valid}, 32'h1);
      check("swp_ill", {31'b0, ill}, {31'b0, W_ILL[i]});
      check("swp_op", {27'b0, op}, {27'b0, W_OP[i]});
      if (i == 4) begin
        check("lh_ldsz", {30'b0, ldsz}, 32'h1);
        check("lh_ldsx", {31'b0, ldsx}, 32'h1);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
